// File: rtl/pipeline_hazard_controller_if.sv
`default_nettype none
// ============================================================================
//  Module      : pipeline_hazard_controller_if
//  Description : Bundles the hazard inputs, event inputs, pipeline-register
//                controls and status outputs of pipeline_hazard_controller.
//                master = pipeline side driving hazards/events,
//                slave  = the hazard controller itself.
//  Revision    : 1.0 - initial release
// ============================================================================
interface pipeline_hazard_controller_if;
    // Hazard detection inputs
    logic        d_readM_EX;
    logic [1:0]  write_reg_addr_EX;
    logic [1:0]  rs_ID;
    logic [1:0]  rt_ID;
    logic        use_rs_ID;
    logic        use_rt_ID;
    // Event inputs
    logic        mispredict_EX;
    logic        i_mem_busy;
    logic        d_mem_busy;
    logic        is_halted_WB;
    // Pipeline register controls
    logic        stall_IF_ID;
    logic        stall_ID_EX;
    logic        stall_EX_MEM;
    logic        stall_MEM_WB;
    logic        flush_IF_ID;
    logic        flush_ID_EX;
    logic        flush_EX_MEM;
    logic        flush_MEM_WB;
    // Status
    logic        pc_write_en;
    logic        halted;
    logic        mem_timeout;
    logic [15:0] cycle_count;
    logic [15:0] stall_count;
    logic [15:0] flush_count;

    modport master (
        output d_readM_EX, write_reg_addr_EX, rs_ID, rt_ID, use_rs_ID, use_rt_ID,
        output mispredict_EX, i_mem_busy, d_mem_busy, is_halted_WB,
        input  stall_IF_ID, stall_ID_EX, stall_EX_MEM, stall_MEM_WB,
        input  flush_IF_ID, flush_ID_EX, flush_EX_MEM, flush_MEM_WB,
        input  pc_write_en, halted, mem_timeout,
        input  cycle_count, stall_count, flush_count
    );

    modport slave (
        input  d_readM_EX, write_reg_addr_EX, rs_ID, rt_ID, use_rs_ID, use_rt_ID,
        input  mispredict_EX, i_mem_busy, d_mem_busy, is_halted_WB,
        output stall_IF_ID, stall_ID_EX, stall_EX_MEM, stall_MEM_WB,
        output flush_IF_ID, flush_ID_EX, flush_EX_MEM, flush_MEM_WB,
        output pc_write_en, halted, mem_timeout,
        output cycle_count, stall_count, flush_count
    );
endinterface
`default_nettype wire

// File: rtl/pipeline_hazard_controller.sv
`default_nettype none
// ============================================================================
//  Module      : pipeline_hazard_controller
//  Description : Stall/flush controller for a 5-stage pipeline. Three-state
//                FSM (RUN, MEM_WAIT, HALT) with a MEM_WAIT watchdog that
//                raises a sticky mem_timeout. Optional performance counters
//                are built when the macro PERF_COUNTER_EN is defined;
//                otherwise the counter outputs are tied to zero.
//  Revision    : 1.0 - initial release
// ============================================================================
module pipeline_hazard_controller (
    input  wire logic                   clk,
    input  wire logic                   reset,
    pipeline_hazard_controller_if.slave hz
);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_HALT     = 2'd2
    } state_t;

    localparam logic [7:0]  C_WD_MAX  = 8'hFF;
    localparam logic [15:0] C_CNT_MAX = 16'hFFFF;

    state_t     state_q, state_d;
    logic [7:0] wd_q, wd_d;
    logic       mem_timeout_q, mem_timeout_d;

    logic       w_load_use;
    logic [7:0] w_wd_inc;
    logic       w_run_eval;
    logic       w_stall_if_id, w_stall_id_ex, w_stall_ex_mem, w_stall_mem_wb;
    logic       w_flush_if_id, w_flush_id_ex, w_flush_ex_mem, w_flush_mem_wb;
    logic       w_pc_write_en;

    // Load-use: EX load whose destination is a source the ID instruction really reads
    assign w_load_use = hz.d_readM_EX &
                        ((hz.use_rs_ID & (hz.rs_ID == hz.write_reg_addr_EX)) |
                         (hz.use_rt_ID & (hz.rt_ID == hz.write_reg_addr_EX)));

    // Watchdog saturates so the sticky flag cannot be missed on wrap
    assign w_wd_inc = (wd_q == C_WD_MAX) ? C_WD_MAX : (wd_q + 8'd1);

    // Next-state and stall/flush decode; reset overrides outputs to a free-running pipe
    always_comb begin
        state_d        = state_q;
        wd_d           = wd_q;
        mem_timeout_d  = mem_timeout_q;
        w_run_eval     = 1'b0;
        w_stall_if_id  = 1'b0;
        w_stall_id_ex  = 1'b0;
        w_stall_ex_mem = 1'b0;
        w_stall_mem_wb = 1'b0;
        w_flush_if_id  = 1'b0;
        w_flush_id_ex  = 1'b0;
        w_flush_ex_mem = 1'b0;
        w_flush_mem_wb = 1'b0;
        w_pc_write_en  = 1'b1;

        case (state_q)
            ST_HALT: begin
                w_stall_if_id  = 1'b1;
                w_stall_id_ex  = 1'b1;
                w_stall_ex_mem = 1'b1;
                w_stall_mem_wb = 1'b1;
                w_pc_write_en  = 1'b0;
            end
            ST_MEM_WAIT: begin
                if (hz.d_mem_busy) begin
                    w_stall_if_id  = 1'b1;
                    w_stall_id_ex  = 1'b1;
                    w_stall_ex_mem = 1'b1;
                    w_flush_mem_wb = 1'b1;
                    w_pc_write_en  = 1'b0;
                    wd_d           = w_wd_inc;
                    if (w_wd_inc == C_WD_MAX) begin
                        mem_timeout_d = 1'b1;
                    end
                end else begin
                    // Memory done: this cycle is decoded exactly like RUN
                    w_run_eval = 1'b1;
                end
            end
            default: begin
                w_run_eval = 1'b1;
            end
        endcase

        if (w_run_eval) begin
            state_d = ST_RUN;
            if (hz.is_halted_WB) begin
                w_stall_if_id  = 1'b1;
                w_stall_id_ex  = 1'b1;
                w_stall_ex_mem = 1'b1;
                w_stall_mem_wb = 1'b1;
                w_pc_write_en  = 1'b0;
                state_d        = ST_HALT;
            end else if (hz.d_mem_busy) begin
                w_stall_if_id  = 1'b1;
                w_stall_id_ex  = 1'b1;
                w_stall_ex_mem = 1'b1;
                w_flush_mem_wb = 1'b1;
                w_pc_write_en  = 1'b0;
                wd_d           = 8'd0;
                state_d        = ST_MEM_WAIT;
            end else if (hz.mispredict_EX) begin
                // Wrong-path instructions in IF and ID are discarded; PC takes the fix-up target
                w_flush_if_id  = 1'b1;
                w_flush_id_ex  = 1'b1;
                w_pc_write_en  = 1'b1;
            end else if (w_load_use) begin
                // Hold the consumer in ID and send a bubble into EX
                w_stall_if_id  = 1'b1;
                w_flush_id_ex  = 1'b1;
                w_pc_write_en  = 1'b0;
            end else if (hz.i_mem_busy) begin
                // Fetch not ready: bubble into ID, older instructions keep moving
                w_flush_if_id  = 1'b1;
                w_pc_write_en  = 1'b0;
            end
        end

        if (reset) begin
            w_stall_if_id  = 1'b0;
            w_stall_id_ex  = 1'b0;
            w_stall_ex_mem = 1'b0;
            w_stall_mem_wb = 1'b0;
            w_flush_if_id  = 1'b0;
            w_flush_id_ex  = 1'b0;
            w_flush_ex_mem = 1'b0;
            w_flush_mem_wb = 1'b0;
            w_pc_write_en  = 1'b1;
        end
    end

    // FSM state, watchdog and sticky timeout registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_RUN;
            wd_q          <= 8'd0;
            mem_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            wd_q          <= wd_d;
            mem_timeout_q <= mem_timeout_d;
        end
    end

    assign hz.stall_IF_ID  = w_stall_if_id;
    assign hz.stall_ID_EX  = w_stall_id_ex;
    assign hz.stall_EX_MEM = w_stall_ex_mem;
    assign hz.stall_MEM_WB = w_stall_mem_wb;
    assign hz.flush_IF_ID  = w_flush_if_id;
    assign hz.flush_ID_EX  = w_flush_id_ex;
    assign hz.flush_EX_MEM = w_flush_ex_mem;
    assign hz.flush_MEM_WB = w_flush_mem_wb;
    assign hz.pc_write_en  = w_pc_write_en;
    assign hz.halted       = (state_q == ST_HALT);
    assign hz.mem_timeout  = mem_timeout_q;

`ifdef PERF_COUNTER_EN
    logic [15:0] cycle_count_q, cycle_count_d;
    logic [15:0] stall_count_q, stall_count_d;
    logic [15:0] flush_count_q, flush_count_d;

    // Saturating performance counter updates
    always_comb begin
        cycle_count_d = cycle_count_q;
        stall_count_d = stall_count_q;
        flush_count_d = flush_count_q;
        if (cycle_count_q != C_CNT_MAX) begin
            cycle_count_d = cycle_count_q + 16'd1;
        end
        if (!w_pc_write_en && (state_q != ST_HALT) && (stall_count_q != C_CNT_MAX)) begin
            stall_count_d = stall_count_q + 16'd1;
        end
        if ((w_flush_if_id || w_flush_id_ex) && (flush_count_q != C_CNT_MAX)) begin
            flush_count_d = flush_count_q + 16'd1;
        end
    end

    // Performance counter registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cycle_count_q <= 16'd0;
            stall_count_q <= 16'd0;
            flush_count_q <= 16'd0;
        end else begin
            cycle_count_q <= cycle_count_d;
            stall_count_q <= stall_count_d;
            flush_count_q <= flush_count_d;
        end
    end

    assign hz.cycle_count = cycle_count_q;
    assign hz.stall_count = stall_count_q;
    assign hz.flush_count = flush_count_q;
`else
    assign hz.cycle_count = 16'd0;
    assign hz.stall_count = 16'd0;
    assign hz.flush_count = 16'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipeline_hazard_controller.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pipeline_hazard_controller
//  Description : Directed self-checking bench for pipeline_hazard_controller.
//                Inputs change 1 time unit after a rising edge; outputs are
//                sampled 1 time unit later.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pipeline_hazard_controller;

    logic clk;
    logic reset;
    int   n_cmp;
    int   n_bad;

    pipeline_hazard_controller_if bus ();

    pipeline_hazard_controller dut (
        .clk   (clk),
        .reset (reset),
        .hz    (bus.slave)
    );

    wire [3:0] stalls  = {bus.stall_IF_ID, bus.stall_ID_EX, bus.stall_EX_MEM, bus.stall_MEM_WB};
    wire [3:0] flushes = {bus.flush_IF_ID, bus.flush_ID_EX, bus.flush_EX_MEM, bus.flush_MEM_WB};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic clear_inputs();
        bus.d_readM_EX        = 1'b0;
        bus.write_reg_addr_EX = 2'd0;
        bus.rs_ID             = 2'd0;
        bus.rt_ID             = 2'd0;
        bus.use_rs_ID         = 1'b0;
        bus.use_rt_ID         = 1'b0;
        bus.mispredict_EX     = 1'b0;
        bus.i_mem_busy        = 1'b0;
        bus.d_mem_busy        = 1'b0;
        bus.is_halted_WB      = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reset pulse spanning one edge; returns 1 unit after an edge with reset low
    task automatic do_reset();
        reset = 1'b1;
        clear_inputs();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        clear_inputs();
        bus.mispredict_EX = 1'b1;
        bus.d_mem_busy    = 1'b1;
        bus.i_mem_busy    = 1'b1;
        tick();
        #1;
        n_cmp++; if (stalls !== 4'b0000) begin n_bad++; $display("FAIL rst_stalls: got %b want %b", stalls, 4'b0000); end
        n_cmp++; if (flushes !== 4'b0000) begin n_bad++; $display("FAIL rst_flushes: got %b want %b", flushes, 4'b0000); end
        n_cmp++; if (bus.pc_write_en !== 1'b1) begin n_bad++; $display("FAIL rst_pc: got %b want 1", bus.pc_write_en); end
        n_cmp++; if ({bus.halted, bus.mem_timeout} !== 2'b00) begin n_bad++; $display("FAIL rst_status: got %b want 00", {bus.halted, bus.mem_timeout}); end
        n_cmp++; if ({bus.cycle_count, bus.stall_count, bus.flush_count} !== 48'd0) begin n_bad++; $display("FAIL rst_counters: got %h want 0", {bus.cycle_count, bus.stall_count, bus.flush_count}); end
        clear_inputs();
        tick();
        reset = 1'b0;
        #1;
        n_cmp++; if ({stalls, flushes, bus.pc_write_en} !== 9'b0000_0000_1) begin n_bad++; $display("FAIL idle: got %b want %b", {stalls, flushes, bus.pc_write_en}, 9'b0000_0000_1); end
    endtask

    task automatic test_load_use();
        clear_inputs();
        bus.d_readM_EX = 1'b1; bus.write_reg_addr_EX = 2'd2; bus.rs_ID = 2'd2; bus.use_rs_ID = 1'b1;
        #1;
        n_cmp++; if ({stalls, flushes, bus.pc_write_en} !== 9'b1000_0100_0) begin n_bad++; $display("FAIL lu_rs: got %b want %b", {stalls, flushes, bus.pc_write_en}, 9'b1000_0100_0); end
        tick();
        clear_inputs();
        #1;
        n_cmp++; if ({stalls, flushes, bus.pc_write_en} !== 9'b0000_0000_1) begin n_bad++; $display("FAIL lu_after: got %b want %b", {stalls, flushes, bus.pc_write_en}, 9'b0000_0000_1); end
        bus.d_readM_EX = 1'b1; bus.write_reg_addr_EX = 2'd3; bus.rt_ID = 2'd3; bus.use_rt_ID = 1'b1; bus.rs_ID = 2'd1; bus.use_rs_ID = 1'b1;
        #1;
        n_cmp++; if ({stalls, flushes, bus.pc_write_en} !== 9'b1000_0100_0) begin n_bad++; $display("FAIL lu_rt: got %b want %b", {stalls, flushes, bus.pc_write_en}, 9'b1000_0100_0); end
        tick();
        clear_inputs();
        bus.d_readM_EX = 1'b1; bus.write_reg_addr_EX = 2'd1; bus.rs_ID = 2'd1; bus.rt_ID = 2'd1;
        #1;
        n_cmp++; if ({stalls, flushes, bus.pc_write_en} !== 9'b0000_0000_1) begin n_bad++; $display("FAIL lu_unused_src: got %b want %b", {stalls, flushes, bus.pc_write_en}, 9'b0000_0000_1); end
        bus.d_readM_EX = 1'b0; bus.use_rs_ID = 1'b1;
        #1;
        n_cmp++; if ({stalls, flushes, bus.pc_write_en} !== 9'b0000_0000_1) begin n_bad++; $display("FAIL lu_no_load: got %b want %b", {stalls, flushes, bus.pc_write_en}, 9'b0000_0000_1); end
        tick();
        clear_inputs();
    endtask

    task automatic test_mispredict();
        clear_inputs();
        bus.mispredict_EX = 1'b1;
        bus.d_readM_EX = 1'b1; bus.write_reg_addr_EX = 2'd2; bus.rs_ID = 2'd2; bus.use_rs_ID = 1'b1;
        #1;
        n_cmp++; if ({stalls, flushes, bus.pc_write_en} !== 9'b0000_1100_1) begin n_bad++; $display("FAIL mp_loaduse: got %b want %b", {stalls, flushes, bus.pc_write_en}, 9'b0000_1100_1); end
        clear_inputs();
        bus.mispredict_EX = 1'b1; bus.i_mem_busy = 1'b1;
        #1;
        n_cmp++; if ({stalls, flushes, bus.pc_write_en} !== 9'b0000_1100_1) begin n_bad++; $display("FAIL mp_imem: got %b want %b", {stalls, flushes, bus.pc_write_en}, 9'b0000_1100_1); end
        tick();
        clear_inputs();
    endtask

    task automatic test_i_mem_busy();
        clear_inputs();
        bus.i_mem_busy = 1'b1;
        #1;
        n_cmp++; if ({stalls, flushes, bus.pc_write_en} !== 9'b0000_1000_0) begin n_bad++; $display("FAIL imem: got %b want %b", {stalls, flushes, bus.pc_write_en}, 9'b0000_1000_0); end
        bus.d_readM_EX = 1'b1; bus.write_reg_addr_EX = 2'd0; bus.use_rt_ID = 1'b1;
        #1;
        n_cmp++; if ({stalls, flushes, bus.pc_write_en} !== 9'b1000_0100_0) begin n_bad++; $display("FAIL imem_vs_lu: got %b want %b", {stalls, flushes, bus.pc_write_en}, 9'b1000_0100_0); end
        tick();
        clear_inputs();
    endtask

    task automatic test_dmem_stall();
        do_reset();
        bus.d_mem_busy = 1'b1;
        bus.mispredict_EX = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_cmp++; if ({stalls, flushes, bus.pc_write_en} !== 9'b1110_0001_0) begin n_bad++; $display("FAIL dmem_cyc%0d: got %b want %b", i, {stalls, flushes, bus.pc_write_en}, 9'b1110_0001_0); end
            tick();
        end
        clear_inputs();
        bus.i_mem_busy = 1'b1;
        #1;
        n_cmp++; if ({stalls, flushes, bus.pc_write_en} !== 9'b0000_1000_0) begin n_bad++; $display("FAIL dmem_exit: got %b want %b", {stalls, flushes, bus.pc_write_en}, 9'b0000_1000_0); end
`ifdef PERF_COUNTER_EN
        n_cmp++; if (bus.stall_count !== 16'd3) begin n_bad++; $display("FAIL dmem_stall_cnt: got %0d want 3", bus.stall_count); end
        n_cmp++; if (bus.cycle_count !== 16'd3) begin n_bad++; $display("FAIL dmem_cycle_cnt: got %0d want 3", bus.cycle_count); end
        n_cmp++; if (bus.flush_count !== 16'd0) begin n_bad++; $display("FAIL dmem_flush_cnt: got %0d want 0", bus.flush_count); end
`else
        n_cmp++; if ({bus.cycle_count, bus.stall_count, bus.flush_count} !== 48'd0) begin n_bad++; $display("FAIL dmem_counters_off: got %h want 0", {bus.cycle_count, bus.stall_count, bus.flush_count}); end
`endif
        tick();
        clear_inputs();
    endtask

    task automatic test_watchdog();
        do_reset();
        bus.d_mem_busy = 1'b1;
        for (int i = 1; i <= 300; i++) begin
            tick();
            if (i == 250) begin
                n_cmp++; if (bus.mem_timeout !== 1'b0) begin n_bad++; $display("FAIL wd_early: got %b want 0", bus.mem_timeout); end
            end
            if (i == 260) begin
                n_cmp++; if (bus.mem_timeout !== 1'b1) begin n_bad++; $display("FAIL wd_rise: got %b want 1", bus.mem_timeout); end
            end
        end
        n_cmp++; if ({stalls, flushes, bus.pc_write_en} !== 9'b1110_0001_0) begin n_bad++; $display("FAIL wd_still_wait: got %b want %b", {stalls, flushes, bus.pc_write_en}, 9'b1110_0001_0); end
        bus.d_mem_busy = 1'b0;
        #1;
        n_cmp++; if ({stalls, flushes, bus.pc_write_en} !== 9'b0000_0000_1) begin n_bad++; $display("FAIL wd_release: got %b want %b", {stalls, flushes, bus.pc_write_en}, 9'b0000_0000_1); end
        tick();
        tick();
        n_cmp++; if (bus.mem_timeout !== 1'b1) begin n_bad++; $display("FAIL wd_sticky: got %b want 1", bus.mem_timeout); end
    endtask

    task automatic test_halt();
        do_reset();
        bus.is_halted_WB = 1'b1;
        #1;
        n_cmp++; if ({stalls, flushes, bus.pc_write_en, bus.halted} !== 10'b1111_0000_0_0) begin n_bad++; $display("FAIL halt_req: got %b want %b", {stalls, flushes, bus.pc_write_en, bus.halted}, 10'b1111_0000_0_0); end
        tick();
        clear_inputs();
        bus.mispredict_EX = 1'b1; bus.d_mem_busy = 1'b1; bus.i_mem_busy = 1'b1;
        #1;
        n_cmp++; if ({stalls, flushes, bus.pc_write_en, bus.halted} !== 10'b1111_0000_0_1) begin n_bad++; $display("FAIL halt_hold: got %b want %b", {stalls, flushes, bus.pc_write_en, bus.halted}, 10'b1111_0000_0_1); end
        tick(); tick(); tick();
        n_cmp++; if ({stalls, flushes, bus.pc_write_en, bus.halted} !== 10'b1111_0000_0_1) begin n_bad++; $display("FAIL halt_hold_later: got %b want %b", {stalls, flushes, bus.pc_write_en, bus.halted}, 10'b1111_0000_0_1); end
`ifdef PERF_COUNTER_EN
        n_cmp++; if (bus.stall_count !== 16'd1) begin n_bad++; $display("FAIL halt_stall_cnt: got %0d want 1", bus.stall_count); end
`endif
        clear_inputs();
        reset = 1'b1;
        #1;
        n_cmp++; if ({stalls, flushes, bus.pc_write_en, bus.halted} !== 10'b0000_0000_1_0) begin n_bad++; $display("FAIL halt_async_rst: got %b want %b", {stalls, flushes, bus.pc_write_en, bus.halted}, 10'b0000_0000_1_0); end
        tick();
        reset = 1'b0;
        tick();
        n_cmp++; if ({stalls, flushes, bus.pc_write_en, bus.halted} !== 10'b0000_0000_1_0) begin n_bad++; $display("FAIL halt_run_after: got %b want %b", {stalls, flushes, bus.pc_write_en, bus.halted}, 10'b0000_0000_1_0); end
    endtask

    task automatic test_mid_reset();
        do_reset();
        bus.mispredict_EX = 1'b1;
        tick();
        clear_inputs();
        bus.d_mem_busy = 1'b1;
        for (int i = 0; i < 270; i++) tick();
        n_cmp++; if (bus.mem_timeout !== 1'b1) begin n_bad++; $display("FAIL mid_pre_timeout: got %b want 1", bus.mem_timeout); end
`ifdef PERF_COUNTER_EN
        n_cmp++; if ({bus.cycle_count, bus.stall_count, bus.flush_count} !== {16'd271, 16'd270, 16'd1}) begin n_bad++; $display("FAIL mid_pre_counters: got %h want %h", {bus.cycle_count, bus.stall_count, bus.flush_count}, {16'd271, 16'd270, 16'd1}); end
`endif
        #2;
        reset = 1'b1;
        #1;
        n_cmp++; if ({bus.cycle_count, bus.stall_count, bus.flush_count} !== 48'd0) begin n_bad++; $display("FAIL mid_counters: got %h want 0", {bus.cycle_count, bus.stall_count, bus.flush_count}); end
        n_cmp++; if ({bus.mem_timeout, bus.halted} !== 2'b00) begin n_bad++; $display("FAIL mid_status: got %b want 00", {bus.mem_timeout, bus.halted}); end
        n_cmp++; if ({stalls, flushes, bus.pc_write_en} !== 9'b0000_0000_1) begin n_bad++; $display("FAIL mid_outputs: got %b want %b", {stalls, flushes, bus.pc_write_en}, 9'b0000_0000_1); end
        tick();
        reset = 1'b0;
        bus.d_mem_busy = 1'b0;
        bus.i_mem_busy = 1'b1;
        #1;
        n_cmp++; if ({stalls, flushes, bus.pc_write_en} !== 9'b0000_1000_0) begin n_bad++; $display("FAIL mid_first_run: got %b want %b", {stalls, flushes, bus.pc_write_en}, 9'b0000_1000_0); end
        tick();
        tick();
`ifdef PERF_COUNTER_EN
        n_cmp++; if (bus.cycle_count !== 16'd2) begin n_bad++; $display("FAIL mid_cycle_restart: got %0d want 2", bus.cycle_count); end
`endif
        clear_inputs();
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        reset = 1'b1;
        clear_inputs();
        test_reset();
        test_load_use();
        test_mispredict();
        test_i_mem_busy();
        test_dmem_stall();
        test_watchdog();
        test_halt();
        test_mid_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
